// File: rtl/uart_tx_if.sv
// Byte-write handshake between a producer and the UART transmitter.
// The master queues a byte; the slave reports holding-register space and frame completion.
interface uart_tx_if;
  logic       iTx_Start;
  logic [7:0] iTx_Data;
  logic       oTx_Ready;
  logic       oTx_Done;

  modport master (output iTx_Start, iTx_Data, input  oTx_Ready, oTx_Done);
  modport slave  (input  iTx_Start, iTx_Data, output oTx_Ready, oTx_Done);
endinterface

// File: rtl/uart_tx.sv
// 8-bit UART transmitter with a one-byte holding register, optional parity and 1/2 stop bits.
// Bit timing comes from a 16x oversample tick; back-to-back frames leave no idle gap.
module uart_tx #(
  parameter int P_PARITY_EN  = 0,
  parameter int P_PARITY_ODD = 0,
  parameter int P_STOP_BITS  = 1
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iB_Tick,
  output logic       oTx,
  output logic       oTx_Busy,
  uart_tx_if.slave   s_if
);
  localparam bit LP_PAR_EN   = (P_PARITY_EN != 0);
  localparam bit LP_PAR_ODD  = (P_PARITY_ODD != 0);
  localparam bit LP_TWO_STOP = (P_STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t     r_state;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic       r_par;
  logic       r_stop_idx;
  logic       r_tx;

  logic w_bit_end, w_last_stop, w_final_stop, w_capture, w_load;

  assign w_bit_end    = iB_Tick && (r_tick_cnt == 4'd15);
  assign w_last_stop  = !LP_TWO_STOP || r_stop_idx;
  assign w_final_stop = (r_state == S_STOP) && w_bit_end && w_last_stop;
  assign w_capture    = s_if.iTx_Start && !r_hold_full;
  // A queued byte loads from IDLE, or straight off the final stop tick for a gapless frame.
  assign w_load       = r_hold_full && ((r_state == S_IDLE) || w_final_stop);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= 4'd0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_par       <= 1'b0;
      r_stop_idx  <= 1'b0;
      r_tx        <= 1'b1;
    end else begin
      if (w_capture) begin
        r_hold      <= s_if.iTx_Data;
        r_hold_full <= 1'b1;
      end
      if (w_load) begin
        r_shift     <= r_hold;
        r_par       <= (^r_hold) ^ LP_PAR_ODD;
        r_hold_full <= 1'b0;
        r_tick_cnt  <= 4'd0;
        r_bit_cnt   <= 3'd0;
        r_stop_idx  <= 1'b0;
        r_tx        <= 1'b0;
        r_state     <= S_START;
      end else if (iB_Tick && (r_state != S_IDLE)) begin
        r_tick_cnt <= r_tick_cnt + 4'd1;
        if (r_tick_cnt == 4'd15) begin
          case (r_state)
            S_START: begin
              r_state <= S_DATA;
              r_tx    <= r_shift[0];
            end
            S_DATA: begin
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_stop_idx <= 1'b0;
                if (LP_PAR_EN) begin
                  r_state <= S_PARITY;
                  r_tx    <= r_par;
                end else begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_tx <= r_shift[1];
              end
            end
            S_PARITY: begin
              r_state    <= S_STOP;
              r_stop_idx <= 1'b0;
              r_tx       <= 1'b1;
            end
            S_STOP: begin
              if (!w_last_stop) begin
                r_stop_idx <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_tx    <= 1'b1;
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign oTx            = r_tx;
  assign oTx_Busy       = (r_state != S_IDLE);
  assign s_if.oTx_Ready = !r_hold_full;
  assign s_if.oTx_Done  = iRst_n && w_final_stop;
endmodule
